// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: PC, IR, DR, A, B, C, register file and ALU.
// All sequencing comes from an external controller through the strobe inputs.
module multicycle_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_pc,
    input  logic        iord,
    input  logic        write_mem,
    input  logic        write_dr,
    input  logic        write_ir,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic        write_c,
    input  logic        alu_srcA,
    input  logic        write_a,
    input  logic        write_b,
    input  logic        write_reg,
    input  logic [1:0]  pcsource,
    input  logic [1:0]  alu_ctrl,
    input  logic [1:0]  alu_srcB,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] ir_data,
    output logic        zero,
    output logic [31:0] pc_out,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_dr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_c;
    logic [31:0] r_rf [32];

    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic [31:0] w_imm;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [31:0] w_pc_next;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_imm     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_wr_idx  = regdst ? w_rd : w_rt;
    assign w_wr_data = memtoreg ? r_dr : r_c;

    // RF[0] is gated on read so it is 0 even before the first reset.
    assign w_rs_val  = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rt_val  = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
    assign dbg_data  = (dbg_addr == 5'd0) ? 32'd0 : r_rf[dbg_addr];

    assign w_alu_a   = alu_srcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        unique case (alu_srcB)
            2'b00: w_alu_b = r_b;
            2'b01: w_alu_b = 32'd4;
            2'b10: w_alu_b = w_imm;
            2'b11: w_alu_b = {w_imm[29:0], 2'b00};
            default: w_alu_b = r_b;
        endcase
    end

    always_comb begin
        w_alu_res = 32'd0;
        unique case (alu_ctrl)
            2'b00: w_alu_res = w_alu_a + w_alu_b;
            2'b01: w_alu_res = w_alu_a - w_alu_b;
            2'b11: w_alu_res = w_alu_a & w_alu_b;
            2'b10: w_alu_res = ~(w_alu_a | w_alu_b);
            default: w_alu_res = 32'd0;
        endcase
    end

    assign zero = (w_alu_res == 32'd0);

    always_comb begin
        w_pc_next = r_pc;
        unique case (pcsource)
            2'b00: w_pc_next = w_alu_res;
            2'b01: w_pc_next = r_c;
            2'b10: w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            2'b11: w_pc_next = r_pc;
            default: w_pc_next = r_pc;
        endcase
    end

    assign mem_addr  = iord ? r_c : r_pc;
    assign mem_wdata = r_b;
    assign mem_we    = write_mem & ~rst;
    assign ir_data   = r_ir;
    assign pc_out    = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= 32'd0;
            r_ir <= 32'd0;
            r_dr <= 32'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_c  <= 32'd0;
        end else begin
            if (write_pc) r_pc <= w_pc_next;
            if (write_ir) r_ir <= mem_rdata;
            if (write_dr) r_dr <= mem_rdata;
            if (write_a)  r_a  <= w_rs_val;
            if (write_b)  r_b  <= w_rt_val;
            if (write_c)  r_c  <= w_alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else if (write_reg && (w_wr_idx != 5'd0)) begin
            r_rf[w_wr_idx] <= w_wr_data;
        end
    end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst, write_c, alu_srcA, write_a, write_b, write_reg  in  1 each  controller strobes and selects.
REQ-005 pcsource  in  2  PC next-value select.
REQ-006 alu_ctrl  in  2  ALU operation: 00 add, 01 sub, 11 and, 10 nor.
REQ-007 alu_srcB  in  2  ALU B operand select.
REQ-008 mem_rdata  in  32  memory read data; combinational with mem_addr.
REQ-009 mem_addr  out  32  memory byte address.
REQ-010 mem_wdata  out  32  store data.
REQ-011 mem_we  out  1  memory write enable.
REQ-012 ir_data  out  32  IR register contents, returned to the controller.
REQ-013 zero  out  1  high when the current ALU result is 0.
REQ-014 pc_out  out  32  PC register, for display.
REQ-015 dbg_addr  in  5  debug register-file read index.
REQ-016 dbg_data  out  32  RF[dbg_addr], combinational.

Function
REQ-017 Registers: PC, IR, DR, A, B, C (32 bits each) and a 32x32 register file; RF[0] reads 0 and ignores writes.
REQ-018 ALU A operand: alu_srcA=0 selects PC; 1 selects A.
REQ-019 ALU B operand: 00 selects B; 01 selects constant 4; 10 selects sext(ir[15:0]); 11 selects sext(ir[15:0])<<2.
REQ-020 The ALU is combinational; add and sub are 32-bit modulo with no overflow flag; zero = (result == 0).
REQ-021 mem_addr = iord ? C : PC; mem_wdata = B; mem_we = write_mem & ~rst.
REQ-022 PC next value: pcsource 00 selects the ALU result; 01 selects C; 10 selects {PC[31:28], ir[25:0], 2'b00}; 11 selects PC (hold).
REQ-023 On each rising edge with rst=0, every enabled register updates in the same cycle:
- write_pc: PC <= next
- write_ir: IR <= mem_rdata
- write_dr: DR <= mem_rdata
- write_a: A <= RF[ir[25:21]]
- write_b: B <= RF[ir[20:16]]
- write_c: C <= ALU result
REQ-024 write_reg: RF[regdst ? ir[15:11] : ir[20:16]] <= (memtoreg ? DR : C).
REQ-025 All register reads, including ir_data and dbg_data, return pre-edge values; when write_reg and write_a/write_b target the same index in one cycle, A/B capture the old value.
REQ-026 Simultaneous write_ir and write_a/write_b: register indices come from the pre-edge IR.
REQ-027 A disabled register holds its value; there is no implicit clearing between instructions.
REQ-028 Register writes take effect at the edge with one-cycle latency; mem_addr, mem_we, zero and dbg_data are combinational.

Reset
REQ-029 When rst=1 at a rising edge: PC, IR, DR, A, B, C and all RF entries become 0; all write strobes are ignored.
REQ-030 While rst=1, mem_we = 0 regardless of write_mem.
REQ-031 After reset: pc_out=0, ir_data=0, zero reflects the combinational ALU result for the current selects.
REQ-032 Reset asserted mid-instruction discards all in-flight state; the first cycle after rst falls behaves identically to power-on.

Verification
REQ-033 Fetch: mem_rdata=0x8C220004, iord=0, write_ir=1, write_pc=1, alu_srcA=0, alu_srcB=01, add, pcsource=00 -> ir_data=0x8C220004, pc_out=4.
REQ-034 R-type: RF[1]=5, RF[2]=3, IR=0x00221822:
- write_a/b, then srcA=1, srcB=00, sub, write_c, then write_reg with regdst=1, memtoreg=0 -> RF[3]=2 (dbg_addr=3 reads 2).
REQ-035 Load/store:
- Load: A=0x10, IR imm=4, srcB=10, add, write_c, then iord=1 -> mem_addr=0x14; write_dr, then write_reg with memtoreg=1, regdst=0 -> RF[rt]=mem_rdata.
- Store: write_mem=1 -> mem_we=1, mem_wdata=B.
REQ-036 Beq: A=B=7, srcA=1, srcB=00, sub -> zero=1; C=0x40, pcsource=01, write_pc=1 -> pc_out=0x40. A=7, B=8 -> zero=0.
REQ-037 Jump: PC=0x10000008, ir[25:0]=0x0000010, pcsource=10, write_pc -> pc_out=0x10000040.
REQ-038 Hazards and reset:
- write_reg to RF[0] -> dbg_data stays 0.
- Same-cycle write_reg to RF[1] and write_a with rs=1 -> A holds the old value.
- rst=1 with write_mem=1 -> mem_we=0 and all registers read 0 next cycle.
